user_io_ctrl: RTL and testbench

USER_IO_CTRL -- requirements
Module: user_io_ctrl

---
 rtl/user_io_pkg.sv | 39 +++
 rtl/user_io_ctrl_if.sv | 18 +
 rtl/user_io_sync_edge.sv | 35 +++
 rtl/user_io_ctrl.sv | 124 ++++++++++++
 tb/tb_user_io_ctrl.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/user_io_pkg.sv
// Shared constants for the user GPIO controller: register offsets, reset values,
// NIO default and Wishbone byte-lane helpers.
package user_io_pkg;

   localparam int unsigned NIO_DEFAULT = 27;
   localparam int unsigned WB_AW       = 32;
   localparam int unsigned WB_DW       = 32;
   localparam int unsigned WB_SW       = WB_DW / 8;

   // Word offsets, decoded from wbs_adr_i[7:2]
   localparam logic [5:0] OFF_OUT  = 6'h00;
   localparam logic [5:0] OFF_OEB  = 6'h01;
   localparam logic [5:0] OFF_IN   = 6'h02;
   localparam logic [5:0] OFF_EDGE = 6'h03;
   localparam logic [5:0] OFF_MASK = 6'h04;
   localparam logic [5:0] OFF_STAT = 6'h05;

   localparam logic [WB_DW-1:0] OUT_RST  = 32'h0000_0000;
   localparam logic [WB_DW-1:0] OEB_RST  = 32'hFFFF_FFFF;
   localparam logic [WB_DW-1:0] EDGE_RST = 32'hFFFF_FFFF;
   localparam logic [WB_DW-1:0] MASK_RST = 32'h0000_0000;
   localparam logic [WB_DW-1:0] STAT_RST = 32'h0000_0000;

   function automatic logic [WB_DW-1:0] sel_mask(input logic [WB_SW-1:0] sel);
      logic [WB_DW-1:0] m;
      m = '0;
      for (int b = 0; b < int'(WB_SW); b++) m[8*b +: 8] = {8{sel[b]}};
      return m;
   endfunction

   function automatic logic [WB_DW-1:0] be_merge(input logic [WB_DW-1:0] old_v,
                                                 input logic [WB_DW-1:0] dat,
                                                 input logic [WB_SW-1:0] sel);
      logic [WB_DW-1:0] m;
      m = sel_mask(sel);
      return (old_v & ~m) | (dat & m);
   endfunction

endpackage

// File: rtl/user_io_ctrl_if.sv
// Wishbone slave bus bundle for the user GPIO controller.
interface user_io_ctrl_if;
   import user_io_pkg::*;

   logic             wbs_cyc_i;
   logic             wbs_stb_i;
   logic             wbs_we_i;
   logic [WB_SW-1:0] wbs_sel_i;
   logic [WB_AW-1:0] wbs_adr_i;
   logic [WB_DW-1:0] wbs_dat_i;
   logic             wbs_ack_o;
   logic [WB_DW-1:0] wbs_dat_o;

   modport slave  (input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
                   output wbs_ack_o, wbs_dat_o);
   modport master (output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
                   input  wbs_ack_o, wbs_dat_o);
endinterface

// File: rtl/user_io_sync_edge.sv
// Pad input synchronizer plus one history stage; emits a per-bit edge pulse of
// the polarity chosen by i_edge_sel (1=rising, 0=falling).
module user_io_sync_edge
   import user_io_pkg::*;
#(
   parameter int unsigned NIO         = NIO_DEFAULT,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [NIO-1:0] i_pad,
   input  logic [NIO-1:0] i_edge_sel,
   output logic [NIO-1:0] o_sync,
   output logic [NIO-1:0] o_edge
);

   logic [NIO-1:0] r_sync [SYNC_STAGES];
   logic [NIO-1:0] r_hist;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < int'(SYNC_STAGES); s++) r_sync[s] <= '0;
         r_hist <= '0;
      end else begin
         r_sync[0] <= i_pad;
         for (int s = 1; s < int'(SYNC_STAGES); s++) r_sync[s] <= r_sync[s-1];
         r_hist <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_sync = r_sync[SYNC_STAGES-1];
   assign o_edge = ( i_edge_sel &  r_sync[SYNC_STAGES-1] & ~r_hist)
                 | (~i_edge_sel & ~r_sync[SYNC_STAGES-1] &  r_hist);

endmodule

// File: rtl/user_io_ctrl.sv
// User GPIO controller: Wishbone register file driving pads, synced inputs and
// sticky edge status. Define USER_IO_IRQ_EN to build the EDGE/MASK/STAT/irq path.
module user_io_ctrl
   import user_io_pkg::*;
#(
   parameter int unsigned NIO         = NIO_DEFAULT,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic           wb_clk_i,
   input  logic           wb_rst_i,
   user_io_ctrl_if.slave  wbs,
   input  logic [NIO-1:0] io_in,
   output logic [NIO-1:0] io_out,
   output logic [NIO-1:0] io_oeb,
   output logic [2:0]     user_irq
);

   logic             w_req;
   logic             w_wr;
   logic [5:0]       w_reg;
   logic [WB_DW-1:0] w_wmask;
   logic [WB_DW-1:0] w_rdata;
   logic [NIO-1:0]   w_sync;
   logic [NIO-1:0]   w_edge;
   logic [NIO-1:0]   w_edge_sel;
   logic [NIO-1:0]   r_out;
   logic [NIO-1:0]   r_oeb;
   logic             r_ack;
   logic [WB_DW-1:0] r_dat;
   logic             w_unused_adr;

   // A new request is only taken while no ack is outstanding
   assign w_req        = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~r_ack;
   assign w_wr         = w_req & wbs.wbs_we_i;
   assign w_reg        = wbs.wbs_adr_i[7:2];
   assign w_wmask      = sel_mask(wbs.wbs_sel_i);
   assign w_unused_adr = ^{wbs.wbs_adr_i[WB_AW-1:8], wbs.wbs_adr_i[1:0]};

   user_io_sync_edge #(
      .NIO         (NIO),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .clk        (wb_clk_i),
      .rst        (wb_rst_i),
      .i_pad      (io_in),
      .i_edge_sel (w_edge_sel),
      .o_sync     (w_sync),
      .o_edge     (w_edge)
   );

`ifdef USER_IO_IRQ_EN
   logic [NIO-1:0] r_edge;
   logic [NIO-1:0] r_mask;
   logic [NIO-1:0] r_stat;
   logic [NIO-1:0] w_clr;
   logic           r_irq;

   assign w_edge_sel = r_edge;
   assign w_clr      = (w_wr && (w_reg == OFF_STAT)) ? NIO'(wbs.wbs_dat_i & w_wmask) : '0;

   // Edge set dominates a simultaneous W1C on the same bit
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_edge <= NIO'(EDGE_RST);
         r_mask <= NIO'(MASK_RST);
         r_stat <= NIO'(STAT_RST);
         r_irq  <= 1'b0;
      end else begin
         if (w_wr && (w_reg == OFF_EDGE))
            r_edge <= NIO'(be_merge(WB_DW'(r_edge), wbs.wbs_dat_i, wbs.wbs_sel_i));
         if (w_wr && (w_reg == OFF_MASK))
            r_mask <= NIO'(be_merge(WB_DW'(r_mask), wbs.wbs_dat_i, wbs.wbs_sel_i));
         r_stat <= (r_stat & ~w_clr) | w_edge;
         r_irq  <= |(r_stat & r_mask);
      end
   end

   assign user_irq = {2'b00, r_irq};
`else
   logic w_unused_edge;

   assign w_edge_sel    = '1;
   assign w_unused_edge = |w_edge;
   assign user_irq      = 3'b000;
`endif

   always_comb begin
      w_rdata = '0;
      case (w_reg)
         OFF_OUT:  w_rdata = WB_DW'(r_out);
         OFF_OEB:  w_rdata = WB_DW'(r_oeb);
         OFF_IN:   w_rdata = WB_DW'(w_sync);
`ifdef USER_IO_IRQ_EN
         OFF_EDGE: w_rdata = WB_DW'(r_edge);
         OFF_MASK: w_rdata = WB_DW'(r_mask);
         OFF_STAT: w_rdata = WB_DW'(r_stat);
`endif
         default:  w_rdata = '0;
      endcase
   end

   // Ack, read data and pad-control writes all land on the same edge
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_ack <= 1'b0;
         r_dat <= '0;
         r_out <= NIO'(OUT_RST);
         r_oeb <= NIO'(OEB_RST);
      end else begin
         r_ack <= w_req;
         r_dat <= w_req ? w_rdata : '0;
         if (w_wr && (w_reg == OFF_OUT))
            r_out <= NIO'(be_merge(WB_DW'(r_out), wbs.wbs_dat_i, wbs.wbs_sel_i));
         if (w_wr && (w_reg == OFF_OEB))
            r_oeb <= NIO'(be_merge(WB_DW'(r_oeb), wbs.wbs_dat_i, wbs.wbs_sel_i));
      end
   end

   assign wbs.wbs_ack_o = r_ack;
   assign wbs.wbs_dat_o = r_dat;
   assign io_out        = r_out;
   assign io_oeb        = r_oeb;

endmodule

// File: tb/tb_user_io_ctrl.sv
// Directed self-checking bench for user_io_ctrl; IRQ checks follow USER_IO_IRQ_EN.
module tb_user_io_ctrl;
   import user_io_pkg::*;

   localparam int unsigned NIO = 27;
   localparam int unsigned SS  = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [NIO-1:0] io_in;
   logic [NIO-1:0] io_out;
   logic [NIO-1:0] io_oeb;
   logic [2:0]     user_irq;
   int             n_pass  = 0;
   int             n_fail  = 0;
   int             n_total = 0;

   always #5 clk = ~clk;

   user_io_ctrl_if u_if ();

   user_io_ctrl #(
      .NIO         (NIO),
      .SYNC_STAGES (SS)
   ) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .wbs      (u_if),
      .io_in    (io_in),
      .io_out   (io_out),
      .io_oeb   (io_oeb),
      .user_irq (user_irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic bus_idle();
      u_if.wbs_cyc_i = 1'b0;
      u_if.wbs_stb_i = 1'b0;
      u_if.wbs_we_i  = 1'b0;
   endtask

   // Returns at the negedge one cycle after the ack cycle
   task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input string tag);
      @(negedge clk);
      u_if.wbs_cyc_i = 1'b1;
      u_if.wbs_stb_i = 1'b1;
      u_if.wbs_we_i  = 1'b1;
      u_if.wbs_adr_i = adr;
      u_if.wbs_dat_i = dat;
      u_if.wbs_sel_i = sel;
      @(negedge clk);
      check({tag, "_ack"}, 32'(u_if.wbs_ack_o), 32'd1);
      bus_idle();
      @(negedge clk);
      check({tag, "_ack_drop"}, 32'(u_if.wbs_ack_o), 32'd0);
   endtask

   task automatic wb_read(input logic [31:0] adr, input logic [31:0] exp, input string tag);
      @(negedge clk);
      u_if.wbs_cyc_i = 1'b1;
      u_if.wbs_stb_i = 1'b1;
      u_if.wbs_we_i  = 1'b0;
      u_if.wbs_adr_i = adr;
      u_if.wbs_sel_i = 4'hF;
      @(negedge clk);
      check({tag, "_ack"}, 32'(u_if.wbs_ack_o), 32'd1);
      check({tag, "_data"}, u_if.wbs_dat_o, exp);
      bus_idle();
      @(negedge clk);
      check({tag, "_dat_idle"}, u_if.wbs_dat_o, 32'd0);
   endtask

   initial begin
      rst   = 1'b1;
      io_in = '0;
      bus_idle();
      u_if.wbs_adr_i = '0;
      u_if.wbs_dat_i = '0;
      u_if.wbs_sel_i = '0;
      repeat (3) @(negedge clk);
      check("rst_ack",  32'(u_if.wbs_ack_o), 32'd0);
      check("rst_dat",  u_if.wbs_dat_o, 32'd0);
      check("rst_out",  32'(io_out), 32'd0);
      check("rst_oeb",  32'(io_oeb), 32'h07FF_FFFF);
      check("rst_irq",  32'(user_irq), 32'd0);
      rst = 1'b0;

      // Byte-lane write then output enable
      wb_write(32'h00, 32'h0000_00A5, 4'b0001, "out_a5");
      check("io_out_a5", 32'(io_out), 32'h0000_00A5);
      check("io_oeb_still_off", 32'(io_oeb), 32'h07FF_FFFF);
      wb_write(32'h04, 32'h0, 4'hF, "oeb0");
      check("io_oeb_on", 32'(io_oeb), 32'd0);

      wb_write(32'h00, 32'h1122_3344, 4'b0100, "out_lane2");
      wb_read(32'h00, 32'h0022_00A5, "rd_out_lane2");

      // Bits above NIO ignore writes
      wb_write(32'h00, 32'hFFFF_FFFF, 4'hF, "out_ones");
      wb_read(32'h00, 32'h07FF_FFFF, "rd_out_ones");
      check("io_out_ones", 32'(io_out), 32'h07FF_FFFF);

      // Unmapped offset and read-only IN
      wb_read(32'h20, 32'h0, "rd_unmapped");
      wb_write(32'h20, 32'h0, 4'hF, "wr_unmapped");
      wb_read(32'h00, 32'h07FF_FFFF, "rd_out_after_unmapped");
      wb_write(32'h08, 32'hFFFF_FFFF, 4'hF, "wr_in");
      wb_read(32'h08, 32'h0, "rd_in_zero");

      // Synchronizer depth: a read started one cycle later still sees the old value
      io_in = 27'h5A5_A5A5;
      wb_read(32'h08, 32'h0, "rd_in_latency");
      wb_read(32'h08, 32'h05A5_A5A5, "rd_in_synced");

`ifdef USER_IO_IRQ_EN
      wb_read(32'h0C, 32'h07FF_FFFF, "rd_edge_rst");
      wb_read(32'h10, 32'h0, "rd_mask_rst");
      wb_read(32'h14, 32'h05A5_A5A5, "rd_stat_rising");
      io_in = '0;
      repeat (4) @(negedge clk);
      wb_write(32'h14, 32'hFFFF_FFFF, 4'hF, "stat_clr_all");
      wb_read(32'h14, 32'h0, "rd_stat_cleared");
      wb_write(32'h10, 32'h8, 4'hF, "mask3");

      // Rising edge on bit 3: STAT at 3rd edge, irq at 4th
      io_in[3] = 1'b1;
      repeat (3) @(negedge clk);
      check("irq_before", 32'(user_irq), 32'd0);
      @(negedge clk);
      check("irq_set", 32'(user_irq), 32'd1);
      wb_read(32'h14, 32'h8, "rd_stat3");

      // W1C coinciding with a new edge: set wins
      io_in[3] = 1'b0;
      repeat (4) @(negedge clk);
      io_in[3] = 1'b1;
      @(negedge clk);
      wb_write(32'h14, 32'h8, 4'hF, "w1c_collide");
      wb_read(32'h14, 32'h8, "rd_stat_set_wins");
      check("irq_held", 32'(user_irq), 32'd1);
      wb_write(32'h14, 32'h8, 4'hF, "w1c_plain");
      wb_read(32'h14, 32'h0, "rd_stat_w1c");
      check("irq_cleared", 32'(user_irq), 32'd0);

      // Falling-edge selection on bit 3
      wb_write(32'h0C, 32'h07FF_FFF7, 4'hF, "edge3_fall");
      io_in[3] = 1'b0;
      repeat (4) @(negedge clk);
      wb_read(32'h14, 32'h8, "rd_stat_fall");
      check("irq_fall", 32'(user_irq), 32'd1);
      wb_write(32'h10, 32'h0, 4'hF, "mask_off");
      repeat (2) @(negedge clk);
      check("irq_masked", 32'(user_irq), 32'd0);
`else
      wb_write(32'h0C, 32'hFFFF_FFFF, 4'hF, "wr_edge");
      wb_write(32'h10, 32'hFFFF_FFFF, 4'hF, "wr_mask");
      wb_write(32'h14, 32'hFFFF_FFFF, 4'hF, "wr_stat");
      wb_read(32'h0C, 32'h0, "rd_edge_off");
      wb_read(32'h10, 32'h0, "rd_mask_off");
      io_in = '0;
      repeat (5) @(negedge clk);
      io_in = '1;
      repeat (5) @(negedge clk);
      check("irq_off", 32'(user_irq), 32'd0);
      wb_read(32'h14, 32'h0, "rd_stat_off");
`endif

      // Reset lands on an in-flight write
      @(negedge clk);
      u_if.wbs_cyc_i = 1'b1;
      u_if.wbs_stb_i = 1'b1;
      u_if.wbs_we_i  = 1'b1;
      u_if.wbs_adr_i = 32'h00;
      u_if.wbs_dat_i = 32'h1234_5678;
      u_if.wbs_sel_i = 4'hF;
      #2 rst = 1'b1;
      @(negedge clk);
      check("midrst_no_ack", 32'(u_if.wbs_ack_o), 32'd0);
      bus_idle();
      @(negedge clk);
      check("midrst_no_ack2", 32'(u_if.wbs_ack_o), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_out", 32'(io_out), 32'd0);
      check("midrst_oeb", 32'(io_oeb), 32'h07FF_FFFF);
      check("midrst_irq", 32'(user_irq), 32'd0);
      wb_read(32'h00, 32'h0, "rd_out_after_rst");
      wb_read(32'h04, 32'h07FF_FFFF, "rd_oeb_after_rst");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
